// File: rtl/parking_gate_ctrl.sv
// Parking gate controller: entry/exit edge detect, password check with lockout, occupancy count.
// Outputs decode state one cycle after the sampling edge; there is no backpressure (inputs are levels/strobes).
module parking_gate_ctrl #(
  parameter int          CAPACITY    = 8,
  parameter logic [3:0]  PASSWORD    = 4'b1011,
  parameter int          GATE_CYCLES = 16,
  parameter int          MAX_TRIES   = 3,
  parameter int          LOCK_CYCLES = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       entry_sensor,
  input  logic       exit_sensor,
  input  logic [3:0] pw,
  input  logic       pw_valid,
  output logic       gate_open,
  output logic       green_led,
  output logic       red_led,
  output logic [3:0] count,
  output logic       full,
  output logic       locked
);

  localparam int GW = $clog2(GATE_CYCLES + 1);
  localparam int LW = $clog2(LOCK_CYCLES + 1);
  localparam int TW = $clog2(MAX_TRIES + 1);
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_CYCLES - 1);
  localparam logic [TW-1:0] TRIES_MAX = TW'(MAX_TRIES);
  localparam logic [3:0]    CAP       = 4'(CAPACITY);

  typedef enum logic [2:0] {IDLE, WAIT_PW, ENTER_OPEN, EXIT_OPEN, LOCKOUT} state_t;

  state_t          state, state_d;
  logic [3:0]      count_q, count_d;
  logic [TW-1:0]   tries, tries_d;
  logic [GW-1:0]   gate_cnt, gate_cnt_d;
  logic [LW-1:0]   lock_cnt, lock_cnt_d;
  logic            entry_q, exit_q;
  logic            entry_rise, exit_rise;

  assign entry_rise = entry_sensor & ~entry_q;
  assign exit_rise  = exit_sensor & ~exit_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      count_q  <= '0;
      tries    <= '0;
      gate_cnt <= '0;
      lock_cnt <= '0;
      entry_q  <= 1'b1;
      exit_q   <= 1'b1;
    end else begin
      state    <= state_d;
      count_q  <= count_d;
      tries    <= tries_d;
      gate_cnt <= gate_cnt_d;
      lock_cnt <= lock_cnt_d;
      entry_q  <= entry_sensor;
      exit_q   <= exit_sensor;
    end
  end

  always_comb begin
    state_d    = state;
    count_d    = count_q;
    tries_d    = tries;
    gate_cnt_d = gate_cnt;
    lock_cnt_d = lock_cnt;
    full       = (count_q == CAP);
    gate_open  = 1'b0;
    green_led  = 1'b0;
    red_led    = 1'b0;
    locked     = 1'b0;
    count      = count_q;

    unique case (state)
      IDLE: begin
        red_led = full;
        // An accepted exit wins and swallows a coincident entry rise.
        if (exit_rise && count_q != 4'd0) begin
          state_d    = EXIT_OPEN;
          gate_cnt_d = '0;
        end else if (entry_rise && !full) begin
          state_d = WAIT_PW;
          tries_d = '0;
        end
      end
      WAIT_PW: begin
        red_led = 1'b1;
        if (!entry_sensor) begin
          state_d = IDLE;
          tries_d = '0;
        end else if (pw_valid) begin
          if (pw == PASSWORD) begin
            state_d    = ENTER_OPEN;
            gate_cnt_d = '0;
          end else begin
            tries_d = tries + 1'b1;
            if (tries + 1'b1 == TRIES_MAX) begin
              state_d    = LOCKOUT;
              lock_cnt_d = '0;
            end
          end
        end
      end
      ENTER_OPEN, EXIT_OPEN: begin
        gate_open = 1'b1;
        green_led = 1'b1;
        if (gate_cnt == GATE_LAST) begin
          state_d = IDLE;
          count_d = (state == ENTER_OPEN) ? count_q + 4'd1 : count_q - 4'd1;
        end else begin
          gate_cnt_d = gate_cnt + 1'b1;
        end
      end
      LOCKOUT: begin
        locked  = 1'b1;
        red_led = 1'b1;
        if (lock_cnt == LOCK_LAST) begin
          state_d = IDLE;
          tries_d = '0;
        end else begin
          lock_cnt_d = lock_cnt + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Bench for parking_gate_ctrl: directed scenarios plus random traffic against a behavioural model.
module tb_parking_gate_ctrl;

  localparam int         CAP  = 8;
  localparam logic [3:0] PASS = 4'b1011;
  localparam int         GATE = 16;
  localparam int         TRY  = 3;
  localparam int         LOCK = 32;

  logic       clk = 1'b0;
  logic       reset;
  logic       entry_sensor, exit_sensor, pw_valid;
  logic [3:0] pw;
  logic       gate_open, green_led, red_led, full, locked;
  logic [3:0] count;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: mode 0 idle, 1 waiting for code, 2 entering, 3 exiting, 4 locked out.
  int m_mode, m_left, m_occ, m_strikes;
  bit m_prev_entry, m_prev_exit, m_valid = 1'b0;

  parking_gate_ctrl #(.CAPACITY(CAP), .PASSWORD(PASS), .GATE_CYCLES(GATE),
                      .MAX_TRIES(TRY), .LOCK_CYCLES(LOCK)) dut (
    .clk(clk), .reset(reset), .entry_sensor(entry_sensor), .exit_sensor(exit_sensor),
    .pw(pw), .pw_valid(pw_valid), .gate_open(gate_open), .green_led(green_led),
    .red_led(red_led), .count(count), .full(full), .locked(locked)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic model_edge();
    bit er, xr;
    if (reset) begin
      m_mode = 0; m_left = 0; m_occ = 0; m_strikes = 0;
      m_prev_entry = 1'b1; m_prev_exit = 1'b1; m_valid = 1'b1;
      return;
    end
    er = entry_sensor && !m_prev_entry;
    xr = exit_sensor && !m_prev_exit;
    case (m_mode)
      0: if (xr && m_occ > 0) begin m_mode = 3; m_left = GATE; end
         else if (er && m_occ < CAP) begin m_mode = 1; m_strikes = 0; end
      1: if (!entry_sensor) begin m_mode = 0; m_strikes = 0; end
         else if (pw_valid) begin
           if (pw == PASS) begin m_mode = 2; m_left = GATE; end
           else begin
             m_strikes++;
             if (m_strikes == TRY) begin m_mode = 4; m_left = LOCK; end
           end
         end
      2, 3: begin
        m_left--;
        if (m_left == 0) begin
          m_occ  = (m_mode == 2) ? m_occ + 1 : m_occ - 1;
          m_mode = 0;
        end
      end
      default: begin
        m_left--;
        if (m_left == 0) begin m_mode = 0; m_strikes = 0; end
      end
    endcase
    m_prev_entry = entry_sensor;
    m_prev_exit  = exit_sensor;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    if (m_valid) begin
      check("gate_open", int'(gate_open), int'(m_mode == 2 || m_mode == 3));
      check("green_led", int'(green_led), int'(m_mode == 2 || m_mode == 3));
      check("red_led", int'(red_led),
            int'(m_mode == 1 || m_mode == 4 || (m_mode == 0 && m_occ == CAP)));
      check("locked", int'(locked), int'(m_mode == 4));
      check("count", int'(count), m_occ);
      check("full", int'(full), int'(m_occ == CAP));
    end
  endtask

  task automatic car_enter();
    entry_sensor = 1'b1; cyc();
    pw = PASS; pw_valid = 1'b1; cyc();
    pw_valid = 1'b0; entry_sensor = 1'b0;
    repeat (GATE + 2) cyc();
  endtask

  task automatic car_exit();
    exit_sensor = 1'b1; cyc();
    exit_sensor = 1'b0;
    repeat (GATE + 2) cyc();
  endtask

  initial begin
    int opens, lk;
    reset = 1'b1; entry_sensor = 1'b0; exit_sensor = 1'b0; pw = 4'd0; pw_valid = 1'b0;
    cyc(); cyc();
    check("rst_gate", int'(gate_open), 0);
    check("rst_red", int'(red_led), 0);
    check("rst_count", int'(count), 0);
    check("rst_locked", int'(locked), 0);
    reset = 1'b0;
    cyc();

    // Single correct entry.
    entry_sensor = 1'b1; cyc();
    check("wait_red", int'(red_led), 1);
    pw = PASS; pw_valid = 1'b1; cyc();
    pw_valid = 1'b0;
    opens = int'(gate_open);
    for (int i = 0; i < 30; i++) begin
      cyc();
      opens += int'(gate_open);
    end
    check("open_cycles", opens, 16);
    check("count_after_enter", int'(count), 1);

    // Three wrong codes, lockout, entry pulse during lockout.
    entry_sensor = 1'b0; cyc();
    entry_sensor = 1'b1; cyc();
    pw = 4'b0000; pw_valid = 1'b1;
    cyc(); cyc(); cyc();
    pw_valid = 1'b0;
    lk = int'(locked);
    entry_sensor = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i == 10) entry_sensor = 1'b1;
      cyc();
      lk += int'(locked);
    end
    check("lock_cycles", lk, 32);
    check("post_lock_red", int'(red_led), 0);
    check("post_lock_gate", int'(gate_open), 0);
    entry_sensor = 1'b0; cyc();
    entry_sensor = 1'b1; cyc();
    pw_valid = 1'b1; cyc(); cyc();
    pw_valid = 1'b0;
    check("tries_cleared", int'(locked), 0);
    entry_sensor = 1'b0; cyc();

    // Fill up, then refused entry.
    repeat (7) car_enter();
    check("full_flag", int'(full), 1);
    check("full_count", int'(count), 8);
    entry_sensor = 1'b1; cyc();
    check("full_red", int'(red_led), 1);
    pw = PASS; pw_valid = 1'b1; cyc();
    pw_valid = 1'b0; cyc();
    check("full_no_gate", int'(gate_open), 0);
    check("full_count_hold", int'(count), 8);
    entry_sensor = 1'b0; cyc();

    // Simultaneous entry and exit at count 2.
    repeat (6) car_exit();
    check("count_two", int'(count), 2);
    entry_sensor = 1'b1; exit_sensor = 1'b1; cyc();
    check("exit_priority_gate", int'(gate_open), 1);
    check("exit_priority_red", int'(red_led), 0);
    entry_sensor = 1'b0; exit_sensor = 1'b0;
    repeat (GATE + 2) cyc();
    check("count_after_exit", int'(count), 1);

    // Exit at zero, then reset during an open gate.
    reset = 1'b1; cyc(); reset = 1'b0; cyc();
    exit_sensor = 1'b1; cyc();
    check("exit_empty_gate", int'(gate_open), 0);
    exit_sensor = 1'b0; cyc();
    entry_sensor = 1'b1; cyc();
    pw = PASS; pw_valid = 1'b1; cyc();
    pw_valid = 1'b0; repeat (4) cyc();
    check("open_before_reset", int'(gate_open), 1);
    reset = 1'b1; cyc();
    check("reset_closes_gate", int'(gate_open), 0);
    check("reset_drops_count", int'(count), 0);
    reset = 1'b0; entry_sensor = 1'b0; cyc();

    // Random traffic.
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(7) == 0) entry_sensor = ~entry_sensor;
      if ($urandom_range(9) == 0) exit_sensor = ~exit_sensor;
      pw_valid = ($urandom_range(3) == 0);
      pw = ($urandom_range(1) == 0) ? PASS : 4'($urandom);
      reset = ($urandom_range(999) == 0);
      cyc();
    end
    reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
